shift_pipe: RTL and testbench

SHIFT_PIPE -- requirements
Module: shift_pipe

---
 rtl/shift_pipe.sv | 122 ++++++++++++
 tb/tb_shift_pipe.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/shift_pipe.sv
// -----------------------------------------------------------------------------
// shift_pipe
//   Pipelined barrel shifter. It has SW = log2(WIDTH) registered stages.
//   Stage k applies a shift of 2^(SW-1-k) when amount bit SW-1-k is set.
//   Valid, mode, amount and tag travel with the data through every stage.
//   A stall at the output freezes the whole pipe. Bubbles are not collapsed.
//
//   Modes: 00 SLL, 01 SRA, 10 ROR, 11 SRL.
//   Optional feature macro: SHIFT_PIPE_ROR_EN.
//     - Defined: mode 10 rotates right.
//     - Undefined: mode 10 behaves as SRL, and no rotate datapath is built.
//
//   Ports:
//     clk, rst            clock and synchronous active-high reset
//     in_valid/in_ready   input handshake (in_ready = !stall)
//     in_data/amt/mode/tag operand, shift amount, shift mode, opaque sideband
//     out_valid/out_ready output handshake
//     out_data/out_tag    result and its tag
//     out_zero            result is zero (qualified by out_valid)
// -----------------------------------------------------------------------------
module shift_pipe #(
    parameter  int WIDTH = 16,
    parameter  int TAG_W = 4,
    localparam int SW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SW-1:0]    in_amt,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_zero
);

    // One fixed-distance shift. Staged SRA is correct because each stage
    // replicates the current MSB, and that MSB still equals the original sign.
    function automatic logic [WIDTH-1:0] f_shift(input logic [WIDTH-1:0] d,
                                                 input logic [1:0]       mode,
                                                 input int               s);
        logic [WIDTH-1:0] res;
        case (mode)
            2'b00:   res = d << s;
            2'b01:   res = $signed(d) >>> s;
`ifdef SHIFT_PIPE_ROR_EN
            2'b10:   res = (d >> s) | (d << (WIDTH - s));
`endif
            default: res = d >> s;
        endcase
        return res;
    endfunction

    // Stage registers
    logic             r_vld  [SW];
    logic [WIDTH-1:0] r_data [SW];
    logic [1:0]       r_mode [SW];
    logic [SW-1:0]    r_amt  [SW];
    logic [TAG_W-1:0] r_tag  [SW];

    // Stage inputs (previous stage, or the input port for stage 0)
    logic             w_vld  [SW];
    logic [WIDTH-1:0] w_data [SW];
    logic [1:0]       w_mode [SW];
    logic [SW-1:0]    w_amt  [SW];
    logic [TAG_W-1:0] w_tag  [SW];
    logic [WIDTH-1:0] w_shf  [SW];
    logic             w_stall;

    assign w_stall  = r_vld[SW-1] && !out_ready;
    assign in_ready = !w_stall;

    always_comb begin
        w_vld[0]  = in_valid;
        w_data[0] = in_data;
        w_mode[0] = in_mode;
        w_amt[0]  = in_amt;
        w_tag[0]  = in_tag;
        for (int k = 1; k < SW; k++) begin
            w_vld[k]  = r_vld[k-1];
            w_data[k] = r_data[k-1];
            w_mode[k] = r_mode[k-1];
            w_amt[k]  = r_amt[k-1];
            w_tag[k]  = r_tag[k-1];
        end
        for (int k = 0; k < SW; k++) begin
            w_shf[k] = w_amt[k][SW-1-k] ? f_shift(w_data[k], w_mode[k], 1 << (SW-1-k))
                                        : w_data[k];
        end
    end

    // A stall freezes every stage, including its valid bit. Reset has priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SW; k++) begin
                r_vld[k]  <= 1'b0;
                r_data[k] <= '0;
                r_mode[k] <= '0;
                r_amt[k]  <= '0;
                r_tag[k]  <= '0;
            end
        end else if (!w_stall) begin
            for (int k = 0; k < SW; k++) begin
                r_vld[k]  <= w_vld[k];
                r_data[k] <= w_shf[k];
                r_mode[k] <= w_mode[k];
                r_amt[k]  <= w_amt[k];
                r_tag[k]  <= w_tag[k];
            end
        end
    end

    assign out_valid = r_vld[SW-1];
    assign out_data  = r_data[SW-1];
    assign out_tag   = r_tag[SW-1];
    assign out_zero  = r_vld[SW-1] && (r_data[SW-1] == '0);

endmodule

// File: tb/tb_shift_pipe.sv
module tb_shift_pipe;
    localparam int WIDTH = 16;
    localparam int TAG_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_data;
    logic [3:0]        in_amt;
    logic [1:0]        in_mode;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_data;
    logic [TAG_W-1:0]  out_tag;
    logic              out_zero;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    shift_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_amt   (in_amt),
        .in_mode  (in_mode),
        .in_tag   (in_tag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_tag  (out_tag),
        .out_zero (out_zero)
    );

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    // Offer one op for a single cycle, then wait (bounded) for its result.
    task automatic run_op(input string name, input logic [15:0] d, input logic [3:0] a,
                          input logic [1:0] m, input logic [3:0] t, input logic [15:0] exp);
        int lat;
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_amt = a; in_mode = m; in_tag = t;
        lat = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 16'($urandom);
            in_amt   = 4'($urandom);
            in_tag   = 4'($urandom);
            lat++;
        end while (!out_valid && lat < 20);
        chk({name, "_latency"}, 64'(lat), 64'd4);
        chk({name, "_data"}, out_data, exp);
        chk({name, "_tag"}, out_tag, t);
        chk({name, "_zero"}, out_zero, (exp == 16'h0));
    endtask

    localparam logic [1:0] SLL = 2'b00, SRA = 2'b01, ROR = 2'b10, SRL = 2'b11;

    initial begin
        logic [15:0] b2b_exp [6];
        logic [15:0] hold_d;
        logic [3:0]  hold_t;
        int issued, got, stall, spur;
        bit seen;

        b2b_exp = '{16'd1, 16'd4, 16'd12, 16'd32, 16'd80, 16'd192};
        hold_d = '0; hold_t = '0;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_amt = '0; in_mode = '0;
        in_tag = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_out_data", out_data, 16'h0);
        chk("reset_out_tag", out_tag, 4'h0);
        chk("reset_out_zero", out_zero, 1'b0);
        chk("reset_in_ready", in_ready, 1'b1);

        run_op("sll15", 16'h0001, 4'd15, SLL, 4'd3, 16'h8000);
        run_op("sra15", 16'h8000, 4'd15, SRA, 4'd1, 16'hFFFF);
        run_op("srl15", 16'h8000, 4'd15, SRL, 4'd2, 16'h0001);
        run_op("sra4",  16'h7FF0, 4'd4,  SRA, 4'd4, 16'h07FF);
`ifdef SHIFT_PIPE_ROR_EN
        run_op("ror4",  16'h1234, 4'd4,  ROR, 4'd5, 16'h4123);
`else
        run_op("ror4",  16'h1234, 4'd4,  ROR, 4'd5, 16'h0123);
`endif
        run_op("sll_zero", 16'h00F0, 4'd12, SLL, 4'd6, 16'h0000);
        run_op("amt0_sll", 16'hA5C3, 4'd0, SLL, 4'd7, 16'hA5C3);
        run_op("amt0_sra", 16'hA5C3, 4'd0, SRA, 4'd8, 16'hA5C3);
        run_op("amt0_ror", 16'hA5C3, 4'd0, ROR, 4'd9, 16'hA5C3);
        run_op("amt0_srl", 16'hA5C3, 4'd0, SRL, 4'd10, 16'hA5C3);

        // Back-to-back ops with a 3-cycle output stall once the first result shows.
        seen = 1'b0; stall = 0; issued = 0; got = 0;
        for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
            @(negedge clk);
            if (out_valid && !seen) begin seen = 1'b1; stall = 3; end
            out_ready = (stall == 0);
            in_valid  = (issued < 6);
            in_data   = 16'(issued + 1);
            in_amt    = 4'(issued);
            in_mode   = SLL;
            in_tag    = 4'(issued);
            #1;
            if (stall > 0) begin
                chk("stall_in_ready", in_ready, 1'b0);
                if (stall < 3) begin
                    chk("stall_hold_data", out_data, hold_d);
                    chk("stall_hold_tag", out_tag, hold_t);
                end
                hold_d = out_data;
                hold_t = out_tag;
                stall--;
            end
            if (out_valid && out_ready) begin
                chk("b2b_tag", out_tag, 64'(got));
                chk("b2b_data", out_data, b2b_exp[got]);
                got++;
            end
            if (in_valid && in_ready) issued++;
        end
        chk("b2b_delivered", 64'(got), 64'd6);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (6) @(negedge clk);

        // Reset with ops in flight and a valid offered during the reset cycle.
        in_valid = 1'b1; in_data = 16'h1111; in_amt = 4'd1; in_mode = SLL; in_tag = 4'd11;
        @(negedge clk);
        in_data = 16'h2222; in_tag = 4'd12;
        @(negedge clk);
        in_data = 16'h3333; in_tag = 4'd13;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; in_data = 16'h4444; in_tag = 4'd14;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        chk("rst_mid_out_valid", out_valid, 1'b0);
        chk("rst_mid_out_data", out_data, 16'h0);
        chk("rst_mid_in_ready", in_ready, 1'b1);
        spur = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) spur++;
        end
        chk("rst_no_output", 64'(spur), 64'd0);
        run_op("post_rst", 16'h0F0F, 4'd1, SRL, 4'd9, 16'h0787);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
